// File: rtl/if_pkg.sv
// Shared types and constants for the prefetching instruction-fetch stage.
package if_pkg;

  localparam int INST_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int CTRL_BIT = 6;

  typedef enum logic [2:0] {
    FIFO_IDLE,
    FIFO_PUSH,
    FIFO_POP,
    FIFO_PUSH_POP,
    FIFO_FLUSH
  } fifo_op_e;

  // One entry of the in-flight return pipe: which beat of which instruction.
  typedef struct packed {
    logic              valid;
    logic [1:0]        beat;
    logic [ADDR_W-1:0] pc;
  } beat_tag_t;

  function automatic int beats_of(input int mem_bytes);
    return 4 / mem_bytes;
  endfunction

endpackage

// File: rtl/stage_if_prefetch_if.sv
// Memory read port between the fetch stage (master) and the memory arbiter (slave).
interface stage_if_prefetch_if #(parameter int MEM_BYTES = 1);
  import if_pkg::*;

  logic                   mem_req_o;
  logic [ADDR_W-1:0]      mem_addr_o;
  logic                   mem_gnt_i;
  logic [8*MEM_BYTES-1:0] mem_data_i;

  modport master (output mem_req_o, mem_addr_o, input mem_gnt_i, mem_data_i);
  modport slave  (input mem_req_o, mem_addr_o, output mem_gnt_i, mem_data_i);

endinterface

// File: rtl/if_inst_fifo.sv
// Synchronous prefetch queue with flush; head is zero whenever the queue is empty.
module if_inst_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  fifo_op_e         op;

  always_comb begin
    op = FIFO_IDLE;
    if (flush)                    op = FIFO_FLUSH;
    else if (push && head_valid && pop) op = FIFO_PUSH_POP;
    else if (push)                op = FIFO_PUSH;
    else if (pop && head_valid)   op = FIFO_POP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      case (op)
        FIFO_FLUSH: begin
          rd_ptr <= '0;
          wr_ptr <= '0;
          count  <= '0;
        end
        FIFO_PUSH: begin
          wr_ptr <= wr_ptr + PW'(1);
          count  <= count + (PW+1)'(1);
        end
        FIFO_POP: begin
          rd_ptr <= rd_ptr + PW'(1);
          count  <= count - (PW+1)'(1);
        end
        FIFO_PUSH_POP: begin
          wr_ptr <= wr_ptr + PW'(1);
          rd_ptr <= rd_ptr + PW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (op == FIFO_PUSH || op == FIFO_PUSH_POP) store[wr_ptr] <= push_data;
  end

  assign head_valid = (count != '0);
  assign head_data  = head_valid ? store[rd_ptr] : '0;

  // The fetch credit scheme must make a push into a full queue impossible.
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                (push && !flush) |-> (count != FULL));

endmodule

// File: rtl/stage_if_prefetch.sv
// Instruction fetch stage: issues MEM_BYTES-wide beats, reassembles 32-bit words and
// queues them for ID; supports redirect/flush and halting after control transfers.
module stage_if_prefetch
  import if_pkg::*;
#(
  parameter int MEM_BYTES    = 1,
  parameter int MEM_LAT      = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter bit STOP_ON_CTRL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stage_if_prefetch_if.master  mem,
  input  logic                 branch_enable_i,
  input  logic [ADDR_W-1:0]    branch_addr_i,
  input  logic                 stall_i,
  output logic                 inst_valid_o,
  output logic [ADDR_W-1:0]    pc_o,
  output logic [INST_W-1:0]    inst_o,
  output logic                 branch_stall_req_o
);

  localparam int         BEATS     = beats_of(MEM_BYTES);
  localparam int         BW        = 8 * MEM_BYTES;
  localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  logic [ADDR_W-1:0]        fetch_pc;
  logic [1:0]               idx;
  logic                     halted;
  logic [CW-1:0]            pend;
  beat_tag_t                pipe [MEM_LAT];
  beat_tag_t                ret;
  logic [INST_W-1:0]        asm_q;
  logic [INST_W-1:0]        asm_next;
  logic                     issue;
  logic                     credit;
  logic                     last_ret;
  logic                     push;
  logic                     pop;
  logic [CW-1:0]            fifo_count;
  logic [ADDR_W+INST_W-1:0] head;

  // pend counts instructions whose first beat has issued but whose last beat has not returned.
  assign credit   = ({1'b0, fifo_count} + {1'b0, pend}) < (CW+1)'(FIFO_DEPTH);
  assign mem.mem_req_o  = rst_n && !halted && !branch_enable_i && (idx != 2'd0 || credit);
  assign mem.mem_addr_o = fetch_pc + ADDR_W'(idx) * ADDR_W'(MEM_BYTES);

  assign issue    = mem.mem_req_o && mem.mem_gnt_i;
  assign ret      = pipe[MEM_LAT-1];
  assign last_ret = ret.valid && (ret.beat == LAST_BEAT);
  assign push     = last_ret && !halted && !branch_enable_i;
  assign pop      = inst_valid_o && !stall_i;

  always_comb begin
    asm_next = asm_q;
    if (ret.valid && !halted) asm_next[BW*int'(ret.beat) +: BW] = mem.mem_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= '0;
      idx      <= 2'd0;
      halted   <= 1'b0;
      pend     <= '0;
      asm_q    <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
    end else if (branch_enable_i) begin
      fetch_pc <= branch_addr_i;
      idx      <= 2'd0;
      halted   <= 1'b0;
      pend     <= '0;
      asm_q    <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= beat_tag_t'({issue, idx, fetch_pc});
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
      asm_q <= asm_next;
      if (issue) begin
        if (idx == LAST_BEAT) begin
          idx      <= 2'd0;
          fetch_pc <= fetch_pc + 32'd4;
        end else begin
          idx <= idx + 2'd1;
        end
      end
      if (push && STOP_ON_CTRL && asm_next[CTRL_BIT]) halted <= 1'b1;
      // Dropped returns while halted still retire their pending slot.
      case ({issue && idx == 2'd0, last_ret})
        2'b10:   pend <= pend + CW'(1);
        2'b01:   pend <= pend - CW'(1);
        default: ;
      endcase
    end
  end

  if_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + INST_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (branch_enable_i),
    .push       (push),
    .pop        (pop),
    .push_data  ({ret.pc, asm_next}),
    .count      (fifo_count),
    .head_valid (inst_valid_o),
    .head_data  (head)
  );

  assign pc_o               = head[ADDR_W+INST_W-1 -: ADDR_W];
  assign inst_o             = head[INST_W-1:0];
  assign branch_stall_req_o = halted;

endmodule

// File: tb/tb_stage_if_prefetch.sv
// Directed bench: a byte-wide fetch stage (stop-on-control) and a word-wide one (no stop).
module tb_stage_if_prefetch;
  import if_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Memory image: word 0 is addi, word 8 is jal, everything else a bit6-clear filler.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A00093;
    if (a == 32'h8) return 32'h0000006F;
    return {a[23:0], 8'h13};
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at({a[31:2], 2'b00});
    return 8'(w >> {a[1:0], 3'b000});
  endfunction

  logic        rst1_n, gnt1, stall1, br1_en;
  logic [31:0] br1_addr;
  logic        valid1, bstall1;
  logic [31:0] pc1, inst1;
  logic [31:0] d1_a0 = '0, d1_a1 = '0;

  stage_if_prefetch_if #(.MEM_BYTES(1)) bus1 ();
  assign bus1.mem_gnt_i  = gnt1;
  assign bus1.mem_data_i = byte_at(d1_a1);
  always @(posedge clk) begin
    d1_a0 <= bus1.mem_addr_o;
    d1_a1 <= d1_a0;
  end

  stage_if_prefetch #(.MEM_BYTES(1), .MEM_LAT(2), .FIFO_DEPTH(4), .STOP_ON_CTRL(1'b1)) dut1 (
    .clk                (clk),
    .rst_n              (rst1_n),
    .mem                (bus1),
    .branch_enable_i    (br1_en),
    .branch_addr_i      (br1_addr),
    .stall_i            (stall1),
    .inst_valid_o       (valid1),
    .pc_o               (pc1),
    .inst_o             (inst1),
    .branch_stall_req_o (bstall1)
  );

  logic        rst4_n, stall4;
  logic        valid4, bstall4;
  logic [31:0] pc4, inst4;
  logic [31:0] d4_a0 = '0, d4_a1 = '0;

  stage_if_prefetch_if #(.MEM_BYTES(4)) bus4 ();
  assign bus4.mem_gnt_i  = 1'b1;
  assign bus4.mem_data_i = word_at({d4_a1[31:2], 2'b00});
  always @(posedge clk) begin
    d4_a0 <= bus4.mem_addr_o;
    d4_a1 <= d4_a0;
  end

  stage_if_prefetch #(.MEM_BYTES(4), .MEM_LAT(2), .FIFO_DEPTH(4), .STOP_ON_CTRL(1'b0)) dut4 (
    .clk                (clk),
    .rst_n              (rst4_n),
    .mem                (bus4),
    .branch_enable_i    (1'b0),
    .branch_addr_i      (32'h0),
    .stall_i            (stall4),
    .inst_valid_o       (valid4),
    .pc_o               (pc4),
    .inst_o             (inst4),
    .branch_stall_req_o (bstall4)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic gnt, input logic stall,
                               input logic br_en, input logic [31:0] br_addr);
    rst1_n   = rst;
    gnt1     = gnt;
    stall1   = stall;
    br1_en   = br_en;
    br1_addr = br_addr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst1_n = 1'b0; gnt1 = 1'b1; stall1 = 1'b1; br1_en = 1'b0; br1_addr = '0;
    rst4_n = 1'b0; stall4 = 1'b1;
    tick(2);
    checkOutput("rst_req",    32'(bus1.mem_req_o), 32'd0);
    checkOutput("rst_addr",   bus1.mem_addr_o,     32'd0);
    checkOutput("rst_valid",  32'(valid1),         32'd0);
    checkOutput("rst_pc",     pc1,                 32'd0);
    checkOutput("rst_inst",   inst1,               32'd0);
    checkOutput("rst_bstall", 32'(bstall1),        32'd0);
    checkOutput("rst_req4",   32'(bus4.mem_req_o), 32'd0);

    // Byte-serial fetch of the first word, stall held so the queue accumulates.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("issue_req",  32'(bus1.mem_req_o), 32'd1);
      checkOutput("issue_addr", bus1.mem_addr_o,     32'(i));
      tick(1);
    end
    tick(1);
    checkOutput("first_valid_early", 32'(valid1), 32'd0);
    tick(1);
    checkOutput("first_valid", 32'(valid1), 32'd1);
    checkOutput("first_pc",    pc1,         32'h0);
    checkOutput("first_inst",  inst1,       32'h00A00093);

    // jal at pc 8 halts prefetch while the pc 12 beats are still in flight.
    tick(8);
    checkOutput("halt_bstall", 32'(bstall1),        32'd1);
    checkOutput("halt_req",    32'(bus1.mem_req_o), 32'd0);
    checkOutput("halt_pc",     pc1,                 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redir40_valid",  32'(valid1),         32'd0);
    checkOutput("redir40_bstall", 32'(bstall1),        32'd0);
    checkOutput("redir40_req",    32'(bus1.mem_req_o), 32'd1);
    checkOutput("redir40_addr",   bus1.mem_addr_o,     32'h40);
    tick(5);
    checkOutput("redir40_valid_early", 32'(valid1), 32'd0);
    tick(1);
    checkOutput("redir40_head_valid", 32'(valid1), 32'd1);
    checkOutput("redir40_head_pc",    pc1,         32'h40);
    checkOutput("redir40_head_inst",  inst1,       32'h00004013);

    // Grant withdrawn after beat 1 of pc 0x44; the address must hold at pc+2.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("nognt_req",  32'(bus1.mem_req_o), 32'd1);
    checkOutput("nognt_addr", bus1.mem_addr_o,     32'h46);
    tick(2);
    checkOutput("nognt_addr_hold", bus1.mem_addr_o, 32'h46);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick(3);
    checkOutput("nognt_valid_early", 32'(valid1), 32'd0);
    tick(1);
    checkOutput("nognt_valid", 32'(valid1), 32'd1);
    checkOutput("nognt_pc",    pc1,         32'h44);
    checkOutput("nognt_inst",  inst1,       32'h00004413);

    // Fill the queue with 3 entries, then redirect with two beats of pc 0x50 in flight.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick(8);
    checkOutput("pre100_pc",   pc1,             32'h44);
    checkOutput("pre100_addr", bus1.mem_addr_o, 32'h52);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
    checkOutput("redir100_req_same", 32'(bus1.mem_req_o), 32'd0);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redir100_valid", 32'(valid1),     32'd0);
    checkOutput("redir100_addr",  bus1.mem_addr_o, 32'h100);
    tick(5);
    checkOutput("redir100_valid_early", 32'(valid1), 32'd0);
    tick(1);
    checkOutput("redir100_head_valid", 32'(valid1), 32'd1);
    checkOutput("redir100_head_pc",    pc1,         32'h100);
    checkOutput("redir100_head_inst",  inst1,       32'h00010013);

    // One-cycle asynchronous reset in the middle of fetching.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("midrst_req",    32'(bus1.mem_req_o), 32'd0);
    checkOutput("midrst_addr",   bus1.mem_addr_o,     32'd0);
    checkOutput("midrst_valid",  32'(valid1),         32'd0);
    checkOutput("midrst_pc",     pc1,                 32'd0);
    checkOutput("midrst_inst",   inst1,               32'd0);
    checkOutput("midrst_bstall", 32'(bstall1),        32'd0);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("restart_req",  32'(bus1.mem_req_o), 32'd1);
    checkOutput("restart_addr", bus1.mem_addr_o,     32'd0);
    tick(6);
    checkOutput("restart_valid", 32'(valid1), 32'd1);
    checkOutput("restart_pc",    pc1,         32'h0);
    checkOutput("restart_inst",  inst1,       32'h00A00093);

    // Word-wide port with ID stalled: credit limits prefetch to four instructions.
    tick(1);
    rst4_n = 1'b1;
    #1;
    checkOutput("w4_first_req",  32'(bus4.mem_req_o), 32'd1);
    checkOutput("w4_first_addr", bus4.mem_addr_o,     32'd0);
    tick(8);
    checkOutput("w4_full_req",   32'(bus4.mem_req_o), 32'd0);
    checkOutput("w4_full_valid", 32'(valid4),         32'd1);
    checkOutput("w4_head0_pc",   pc4,                 32'h0);
    checkOutput("w4_head0_inst", inst4,               32'h00A00093);
    stall4 = 1'b0;
    #1;
    tick(1);
    checkOutput("w4_head1_pc",     pc4,             32'h4);
    checkOutput("w4_head1_inst",   inst4,           32'h00000413);
    checkOutput("w4_resume_req",   32'(bus4.mem_req_o), 32'd1);
    checkOutput("w4_resume_addr",  bus4.mem_addr_o, 32'h10);
    tick(1);
    checkOutput("w4_head2_pc",   pc4,   32'h8);
    checkOutput("w4_head2_inst", inst4, 32'h0000006F);
    tick(1);
    checkOutput("w4_head3_pc",   pc4,   32'hC);
    tick(1);
    checkOutput("w4_head4_valid", 32'(valid4), 32'd1);
    checkOutput("w4_head4_pc",    pc4,         32'h10);
    checkOutput("w4_head4_inst",  inst4,       32'h00001013);
    checkOutput("w4_no_stall",    32'(bstall4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
